// File: rtl/dcache_refill_ctl.sv
// dcache_refill_ctl
//   Memory-side miss handler for the set-associative data cache. A miss,
//   optionally with a dirty victim, is accepted in IDLE. The victim line is
//   written back as BEATS single-beat writes. The missing line is then read
//   as one burst request, its beats are assembled into a LINE_W line, and the
//   line is returned with a one-cycle response pulse. The pipeline is stalled
//   from the first memory request until the last read beat has arrived.
//
// Ports
//   clk, rst              clock; asynchronous active-low reset
//   i_cache_miss          miss request, sampled only in IDLE
//   i_miss_addr           byte address of the missing line
//   i_evict               victim must be written back (sampled with the miss)
//   i_evict_addr/_data    victim line byte address and data
//   o_memory_line         assembled refill line
//   o_memory_response     one-cycle pulse: o_memory_line is valid
//   o_stall               hold the pipeline
//   o_mem_req/_we/_addr   memory request: valid, write(1)/read(0), byte addr
//   o_mem_wdata           write beat data
//   i_mem_gnt             request accepted when o_mem_req & i_mem_gnt
//   i_mem_rvalid/_rdata   read beat valid and data
module dcache_refill_ctl #(
  parameter int ADDR_W   = 32,
  parameter int LINE_W   = 512,
  parameter int BUS_W    = 32,
  parameter int OFFSET_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cache_miss,
  input  logic [ADDR_W-1:0] i_miss_addr,
  input  logic              i_evict,
  input  logic [ADDR_W-1:0] i_evict_addr,
  input  logic [LINE_W-1:0] i_evict_data,
  output logic [LINE_W-1:0] o_memory_line,
  output logic              o_memory_response,
  output logic              o_stall,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [BUS_W-1:0]  o_mem_wdata,
  input  logic              i_mem_gnt,
  input  logic              i_mem_rvalid,
  input  logic [BUS_W-1:0]  i_mem_rdata
);

  localparam int BEATS = LINE_W / BUS_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(BEATS - 1);
  localparam logic [ADDR_W-1:0] BEAT_BYTES = ADDR_W'(BUS_W / 8);
  // Clears the line byte-offset bits of an address.
  localparam logic [ADDR_W-1:0] BASE_MASK  = ~((ADDR_W'(1) << OFFSET_W) - ADDR_W'(1));

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WB      = 3'd1;
  localparam logic [2:0] S_RD_REQ  = 3'd2;
  localparam logic [2:0] S_RD_DATA = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;

  logic [2:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_resp;
  logic [LINE_W-1:0] r_line;
  logic [ADDR_W-1:0] r_miss_base;
  logic [ADDR_W-1:0] r_evict_base;
  logic [LINE_W-1:0] r_evict_data;
  logic [BUS_W-1:0]  w_wb_word;

  // Control state and the returned line; the line is cleared on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_resp  <= 1'b0;
      r_line  <= '0;
    end else begin
      r_resp <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_cache_miss) begin
            r_state <= i_evict ? S_WB : S_RD_REQ;
          end
        end
        S_WB: begin
          if (i_mem_gnt) begin
            if (r_cnt == LAST_BEAT) begin
              r_cnt   <= '0;
              r_state <= S_RD_REQ;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_RD_REQ: begin
          if (i_mem_gnt) begin
            r_state <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (i_mem_rvalid) begin
            for (int b = 0; b < BEATS; b++) begin
              if (r_cnt == CNT_W'(b)) begin
                r_line[b*BUS_W +: BUS_W] <= i_mem_rdata;
              end
            end
            if (r_cnt == LAST_BEAT) begin
              r_cnt   <= '0;
              r_state <= S_RESP;
              r_resp  <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Miss context captured once per transaction; needs no reset because it is
  // only observed while a transaction it belongs to is in flight.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && i_cache_miss) begin
      r_miss_base  <= i_miss_addr & BASE_MASK;
      r_evict_base <= i_evict_addr & BASE_MASK;
      r_evict_data <= i_evict_data;
    end
  end

  // Current write-back beat selected from the captured victim line.
  always_comb begin
    w_wb_word = '0;
    for (int b = 0; b < BEATS; b++) begin
      if (r_cnt == CNT_W'(b)) begin
        w_wb_word = r_evict_data[b*BUS_W +: BUS_W];
      end
    end
  end

  // Request outputs decode from registered state; address and data are
  // forced to zero whenever no request is presented.
  always_comb begin
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    case (r_state)
      S_WB: begin
        o_mem_req   = 1'b1;
        o_mem_we    = 1'b1;
        o_mem_addr  = r_evict_base + ADDR_W'(r_cnt) * BEAT_BYTES;
        o_mem_wdata = w_wb_word;
      end
      S_RD_REQ: begin
        o_mem_req  = 1'b1;
        o_mem_addr = r_miss_base;
      end
      default: begin
      end
    endcase
  end

  assign o_stall           = (r_state == S_WB) || (r_state == S_RD_REQ) ||
                             (r_state == S_RD_DATA);
  assign o_memory_response = r_resp;
  assign o_memory_line     = r_line;

endmodule

// File: doc/dcache_refill_ctl.md
Name: dcache_refill_ctl

Overview:
- Memory-side miss handler for the set-associative data cache in the pipelined CPU top.
- Takes a miss (plus an optional dirty eviction) from the cache and writes the victim line back as BUS_W-wide beats.
- Then fetches the missing line as a burst, assembles it into a full LINE_W line, and returns it with a one-cycle response pulse.
- Parametrised in line width, bus width and address width; holds the pipeline stall for the whole transaction.

Parameters:
ADDR_W, 32, byte-address width
LINE_W, 512, cache line width in bits; must be an integer multiple of BUS_W
BUS_W, 32, memory bus data width in bits; BEATS = LINE_W/BUS_W, must be ≥ 2
OFFSET_W, 6, line byte-offset bits; log2(LINE_W/8)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
i_cache_miss  input  1  cache miss request, sampled only in IDLE
i_miss_addr  input  ADDR_W  byte address of missing line
i_evict  input  1  dirty victim must be written back; sampled with i_cache_miss
i_evict_addr  input  ADDR_W  byte address of victim line
i_evict_data  input  LINE_W  victim line data
o_memory_line  output  LINE_W  assembled refill line
o_memory_response  output  1  one-cycle pulse: o_memory_line valid
o_stall  output  1  hold pipeline
o_mem_req  output  1  memory request valid
o_mem_we  output  1  1 = write beat, 0 = line read burst
o_mem_addr  output  ADDR_W  request byte address
o_mem_wdata  output  BUS_W  write beat data
i_mem_gnt  input  1  request accepted when o_mem_req & i_mem_gnt
i_mem_rvalid  input  1  read beat valid
i_mem_rdata  input  BUS_W  read beat data

Behaviour:
- Reset (rst low, async): state IDLE, beat counter 0, all outputs 0, including o_memory_line. Reset mid-transaction abandons it; no further requests issue.
- States: IDLE, WB, RD_REQ, RD_DATA, RESP.
- IDLE, on i_cache_miss=1:
  - Latch miss_addr and evict_addr, each with the low OFFSET_W bits forced to 0.
  - Latch evict_data.
  - Next state is WB if i_evict=1, else RD_REQ.
  - i_evict with i_cache_miss=0 is ignored.
- WB:
  - o_mem_req=1, o_mem_we=1.
  - o_mem_addr = evict_base + k*(BUS_W/8).
  - o_mem_wdata = evict_data[k*BUS_W +: BUS_W].
  - k increments on each grant. On the grant of beat BEATS-1: k←0, go to RD_REQ.
  - Request stays stable while gnt=0.
- RD_REQ:
  - o_mem_req=1, o_mem_we=0, o_mem_addr = miss_base.
  - On gnt, go to RD_DATA.
- RD_DATA:
  - o_mem_req=0.
  - Each i_mem_rvalid writes i_mem_rdata to line[k*BUS_W +: BUS_W] and k increments.
  - After beat BEATS-1: k←0, go to RESP.
  - Gaps in rvalid are allowed.
- RESP:
  - o_memory_response=1 for exactly this cycle, then IDLE.
  - o_memory_line holds its value until the next refill's first rdata beat.
- o_stall = 1 in WB, RD_REQ and RD_DATA; 0 in IDLE and RESP.
- Minimum latency, miss to response, with no eviction and gnt/rvalid immediate: 1 (RD_REQ) + BEATS (RD_DATA) + 1 (RESP) = BEATS+2 cycles.
- Boundary rules:
  - i_cache_miss outside IDLE is ignored; the cache keeps it asserted.
  - A miss asserted during the RESP cycle is taken on the following IDLE cycle.
  - i_mem_rvalid outside RD_DATA is ignored and line data does not change.
  - Counter width is clog2(BEATS); its wrap is not reachable.
  - o_mem_wdata/o_mem_addr are 0 when o_mem_req=0.
- Widths: beat address increment uses ADDR_W arithmetic and wraps modulo 2^ADDR_W.
- All outputs are registered except o_stall, o_mem_req, o_mem_we, o_mem_addr and o_mem_wdata, which decode from registered state only.

Test Plan:
1. Clean miss (defaults, BEATS=16): miss_addr=0x0000_1234, i_evict=0, gnt=1, rvalid every cycle with rdata=beat index.
   - Required: one read request at 0x0000_1200.
   - Response pulse 18 cycles after the miss cycle.
   - o_memory_line[31:0]=0, [511:480]=15.
   - o_stall high for 17 cycles.
2. Dirty miss: evict_addr=0x0000_8040, evict_data word k = 0xA000_0000+k, miss_addr=0x0000_0080.
   - Required: 16 writes at 0x8040, 0x8044 … 0x807C carrying 0xA000_0000 … 0xA000_000F.
   - Then a read at 0x0080, then the response.
3. Backpressure: gnt low 3 cycles on write beat 5 and 2 cycles on the read request.
   - Required: addr/wdata stable throughout; beat order unchanged; response delayed by exactly 5 cycles versus scenario 2.
4. Bubbled read data: rvalid every other cycle.
   - Required: line assembled correctly; response one cycle after the 16th beat.
   - Spurious rvalid asserted in IDLE: no change to o_memory_line.
5. Reset mid-operation: rst low during WB beat 7.
   - Required: immediately o_mem_req=0, o_stall=0, o_memory_response=0, o_memory_line=0.
   - After release, a new miss restarts from beat 0.
6. Back-to-back: second miss asserted in the RESP cycle.
   - Required: first response pulse, one IDLE cycle, then the second read request at the new line address.
